// File: rtl/stream_demux_1ton.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1ton
// Purpose  : Registered 1-to-N stream demultiplexer. A valid/ready handshake
//            is used on the input and on every output channel. Each channel
//            has a one-entry holding register, so a stalled consumer only
//            back-pressures words addressed to it. The block also supports
//            broadcast to all channels, and it keeps a saturating count of
//            words dropped because their select was out of range.
// Ports    : clk, rst             - rising-edge clock, synchronous active-high
//                                   reset
//            data_in/select/bcast - input word, destination, broadcast flag
//            in_valid/in_ready    - producer handshake (in_ready is
//                                   combinational)
//            out_data/out_valid   - per-channel holding registers; channel i
//                                   is at [i*DATA_W +: DATA_W]
//            out_ready            - per-channel consumer ready
//            err_cnt              - dropped out-of-range words, saturates at
//                                   255
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [SEL_W-1:0]       select,
    input  logic                   bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [7:0]             err_cnt
);

    // The channel count is held one bit wider than select, so that N_CH ==
    // 2**SEL_W can still be represented.
    localparam logic [SEL_W:0] c_num_ch  = N_CH[SEL_W:0];
    localparam logic [7:0]     c_err_max = 8'hFF;

    logic [N_CH*DATA_W-1:0] data_q,  data_d;
    logic [N_CH-1:0]        valid_q, valid_d;
    logic [7:0]             err_q,   err_d;

    logic [N_CH-1:0]        w_can_take;
    logic [N_CH-1:0]        w_hit;      // one-hot unicast target (in range only)
    logic [N_CH-1:0]        w_load;
    logic                   w_in_range;
    logic                   w_xfer;
    logic                   w_drop;

    // Handshake decode
    always_comb begin
        w_can_take = ~valid_q | out_ready;
        w_in_range = ({1'b0, select} < c_num_ch);
        w_hit      = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_hit[i] = ~bcast & w_in_range & (select == SEL_W'(i));
        end

        if (bcast) begin
            // All-or-nothing: every channel must be able to take the word.
            in_ready = &w_can_take;
        end else if (w_in_range) begin
            in_ready = |(w_hit & w_can_take);
        end else begin
            // An out-of-range word is always swallowed.
            in_ready = 1'b1;
        end

        w_xfer = in_valid & in_ready;
        w_drop = w_xfer & ~bcast & ~w_in_range;
        w_load = {N_CH{w_xfer}} & ({N_CH{bcast}} | w_hit);
    end

    // Next state
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        for (int i = 0; i < N_CH; i++) begin
            // A load wins over a same-cycle drain, so the channel stays full
            // and now holds the new word. A drain alone leaves the data as is.
            valid_d[i] = w_load[i] | (valid_q[i] & ~out_ready[i]);
            if (w_load[i]) begin
                data_d[i*DATA_W +: DATA_W] = data_in;
            end
        end
        if (w_drop && (err_q != c_err_max)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err_cnt   = err_q;

endmodule
`default_nettype wire
